pulp_clock_gate_ctrl: RTL and testbench

- Control end of the clock-gating path. Generates the enable for a downstream pulp_clock_gating cell, which the parent instantiates.
- Watches an idle/busy indication from the gated domain and runs a stop-request/acknowledge handshake before turning the clock off.
- Re-enables the clock on wake request or forced-on, then reports when the clock is stable.
- Sits in the always-on domain next to each gateable peripheral or cluster.

---
 rtl/pulp_clk_gate_pkg.sv | 14 +
 rtl/pulp_clock_gate_ctrl.sv | 132 +++++++++++++
 tb/tb_pulp_clock_gate_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pulp_clk_gate_pkg.sv
// Shared types and defaults for the always-on clock-gate controller.
// The controller FSM walks ON -> DRAIN -> OFF -> WAKE -> ON.
package pulp_clk_gate_pkg;

    typedef enum logic [1:0] {
        ON    = 2'd0,
        DRAIN = 2'd1,
        OFF   = 2'd2,
        WAKE  = 2'd3
    } clk_gate_state_e;

    localparam int unsigned WAKE_CYCLES_DEFAULT = 2;

endpackage : pulp_clk_gate_pkg

// File: rtl/pulp_clock_gate_ctrl.sv
// Always-on controller producing the enable for a downstream clock-gate cell:
// idle detection, stop-request/ack handshake, wake sequencing and clock-ready status.
module pulp_clock_gate_ctrl
    import pulp_clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_CNT_WIDTH = 8,
    parameter int unsigned WAKE_CYCLES    = WAKE_CYCLES_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_en_i,
    input  logic                      force_on_i,
    input  logic [IDLE_CNT_WIDTH-1:0] idle_thresh_i,
    input  logic                      busy_i,
    input  logic                      wake_req_i,
    output logic                      stop_req_o,
    input  logic                      stop_ack_i,
    output logic                      clk_en_o,
    output logic                      clk_ready_o,
    output logic                      gated_o
);

    localparam logic [IDLE_CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [IDLE_CNT_WIDTH-1:0] WAKE_LOAD = IDLE_CNT_WIDTH'(WAKE_CYCLES - 1);

    clk_gate_state_e           state_q, state_d;
    logic [IDLE_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      clk_en_q, clk_en_d;
    logic                      stop_req_q, stop_req_d;
    logic                      clk_ready_q, clk_ready_d;
    logic                      gated_q, gated_d;

    logic                      idle;
    logic                      wake_any;
    logic [IDLE_CNT_WIDTH:0]   cnt_inc;
    logic [IDLE_CNT_WIDTH-1:0] cnt_sat_inc;
    logic                      thresh_hit;

    assign idle     = ~busy_i & ~wake_req_i & ~force_on_i;
    assign wake_any = wake_req_i | force_on_i;

    // One extra bit so cnt+1 cannot wrap before the threshold compare.
    assign cnt_inc     = {1'b0, cnt_q} + (IDLE_CNT_WIDTH + 1)'(1);
    assign cnt_sat_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[IDLE_CNT_WIDTH-1:0];
    assign thresh_hit  = (idle_thresh_i != '0) && (cnt_inc >= {1'b0, idle_thresh_i});

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        clk_en_d    = clk_en_q;
        stop_req_d  = stop_req_q;
        clk_ready_d = clk_ready_q;
        gated_d     = gated_q;

        unique case (state_q)
            ON: begin
                if (idle) begin
                    cnt_d = cnt_sat_inc;
                    if (thresh_hit) begin
                        state_d    = DRAIN;
                        stop_req_d = 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            DRAIN: begin
                // Renewed activity wins over a same-edge acknowledge.
                if (!idle) begin
                    state_d    = ON;
                    stop_req_d = 1'b0;
                    cnt_d      = '0;
                end else if (stop_ack_i) begin
                    state_d     = OFF;
                    clk_en_d    = 1'b0;
                    clk_ready_d = 1'b0;
                    gated_d     = 1'b1;
                end
            end

            OFF: begin
                if (wake_any) begin
                    state_d    = WAKE;
                    clk_en_d   = 1'b1;
                    stop_req_d = 1'b0;
                    gated_d    = 1'b0;
                    cnt_d      = WAKE_LOAD;
                end
            end

            WAKE: begin
                if (cnt_q == '0) begin
                    state_d     = ON;
                    clk_ready_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q - IDLE_CNT_WIDTH'(1);
                end
            end

            default: begin
                state_d = ON;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ON;
            cnt_q       <= '0;
            clk_en_q    <= 1'b1;
            stop_req_q  <= 1'b0;
            clk_ready_q <= 1'b1;
            gated_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_en_q    <= clk_en_d;
            stop_req_q  <= stop_req_d;
            clk_ready_q <= clk_ready_d;
            gated_q     <= gated_d;
        end
    end

    // Test mode must be able to open the gate regardless of controller state.
    assign clk_en_o    = clk_en_q | test_en_i;
    assign stop_req_o  = stop_req_q;
    assign clk_ready_o = clk_ready_q;
    assign gated_o     = gated_q;

endmodule : pulp_clock_gate_ctrl

// File: tb/tb_pulp_clock_gate_ctrl.sv
// Self-checking bench for pulp_clock_gate_ctrl: a behavioural model checked every
// cycle plus directed scenarios with literal expectations.
module tb_pulp_clock_gate_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned WC = 2;

    logic         clk;
    logic         rst_n;
    logic         test_en;
    logic         force_on;
    logic [W-1:0] thresh;
    logic         busy;
    logic         wake;
    logic         stop_req;
    logic         stop_ack;
    logic         clk_en;
    logic         clk_ready;
    logic         gated;

    int n_cmp  = 0;
    int n_fail = 0;

    pulp_clock_gate_ctrl #(
        .IDLE_CNT_WIDTH (W),
        .WAKE_CYCLES    (WC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .test_en_i     (test_en),
        .force_on_i    (force_on),
        .idle_thresh_i (thresh),
        .busy_i        (busy),
        .wake_req_i    (wake),
        .stop_req_o    (stop_req),
        .stop_ack_i    (stop_ack),
        .clk_en_o      (clk_en),
        .clk_ready_o   (clk_ready),
        .gated_o       (gated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: the controller's situation is read from the output flags.
    bit m_en    = 1'b1;
    bit m_stop  = 1'b0;
    bit m_ready = 1'b1;
    bit m_gated = 1'b0;
    int m_run   = 0;
    int m_woke  = 0;

    always @(posedge clk or negedge rst_n) begin
        bit quiet, running, draining, is_off, waking;
        if (!rst_n) begin
            m_en = 1'b1; m_stop = 1'b0; m_ready = 1'b1; m_gated = 1'b0;
            m_run = 0; m_woke = 0;
        end else begin
            quiet    = !busy && !wake && !force_on;
            running  = m_en && !m_stop && m_ready;
            draining = m_en && m_stop;
            is_off   = !m_en;
            waking   = m_en && !m_stop && !m_ready;
            if (running) begin
                if (quiet) begin
                    m_run++;
                    if (thresh != 0 && m_run >= int'(thresh)) m_stop = 1'b1;
                end else begin
                    m_run = 0;
                end
            end else if (draining) begin
                if (!quiet) begin
                    m_stop = 1'b0; m_run = 0;
                end else if (stop_ack) begin
                    m_en = 1'b0; m_ready = 1'b0; m_gated = 1'b1;
                end
            end else if (is_off) begin
                if (wake || force_on) begin
                    m_en = 1'b1; m_stop = 1'b0; m_gated = 1'b0; m_woke = 0;
                end
            end else if (waking) begin
                m_woke++;
                if (m_woke == WC) begin
                    m_ready = 1'b1; m_run = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        check("model clk_en_o",    clk_en,    m_en | test_en);
        check("model stop_req_o",  stop_req,  m_stop);
        check("model clk_ready_o", clk_ready, m_ready);
        check("model gated_o",     gated,     m_gated);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic expect_all(input string tag, input logic e_en, input logic e_stop,
                              input logic e_rdy, input logic e_gated);
        check({tag, " clk_en_o"},    clk_en,    e_en);
        check({tag, " stop_req_o"},  stop_req,  e_stop);
        check({tag, " clk_ready_o"}, clk_ready, e_rdy);
        check({tag, " gated_o"},     gated,     e_gated);
    endtask

    initial begin
        rst_n = 1'b0;
        test_en = 1'b0; force_on = 1'b0; thresh = 8'd4;
        busy = 1'b1; wake = 1'b0; stop_ack = 1'b0;
        step(2);
        expect_all("reset", 1'b1, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        step();
        expect_all("after reset", 1'b1, 1'b0, 1'b1, 1'b0);

        // Four idle edges with threshold 4, then acknowledge.
        busy = 1'b0;
        step(3);
        check("idle3 stop_req_o", stop_req, 1'b0);
        step();
        expect_all("idle4 drain", 1'b1, 1'b1, 1'b1, 1'b0);
        stop_ack = 1'b1;
        step();
        stop_ack = 1'b0;
        expect_all("ack off", 1'b0, 1'b1, 1'b0, 1'b1);

        // Wake pulse: enable next cycle, ready two edges after.
        wake = 1'b1;
        step();
        wake = 1'b0;
        expect_all("wake edge", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        check("wake+1 clk_ready_o", clk_ready, 1'b0);
        step();
        check("wake+2 clk_ready_o", clk_ready, 1'b1);

        // Busy blip after three idle edges restarts the count.
        step(3);
        busy = 1'b1;
        step();
        busy = 1'b0;
        check("busy blip stop_req_o", stop_req, 1'b0);
        step(3);
        check("recount3 stop_req_o", stop_req, 1'b0);
        step();
        check("recount4 stop_req_o", stop_req, 1'b1);

        // Wake and ack on the same edge in DRAIN: abort wins.
        wake = 1'b1; stop_ack = 1'b1;
        step();
        wake = 1'b0; stop_ack = 1'b0; busy = 1'b1;
        expect_all("abort", 1'b1, 1'b0, 1'b1, 1'b0);
        step();

        // Auto-gating disabled, then held off by force_on.
        busy = 1'b0; thresh = 8'd0;
        step(300);
        check("thresh0 stop_req_o", stop_req, 1'b0);
        thresh = 8'd4; force_on = 1'b1;
        step(300);
        check("force_on stop_req_o", stop_req, 1'b0);
        force_on = 1'b0;
        step(4);
        check("post-force drain stop_req_o", stop_req, 1'b1);
        stop_ack = 1'b1;
        step();
        stop_ack = 1'b0;
        check("force test off gated_o", gated, 1'b1);
        force_on = 1'b1;
        step();
        expect_all("force wake", 1'b1, 1'b0, 1'b0, 1'b0);
        step(2);
        check("force wake ready", clk_ready, 1'b1);
        force_on = 1'b0; busy = 1'b1;
        step();

        // Threshold at all-ones, then a threshold lowered mid-count.
        busy = 1'b0; thresh = 8'd255;
        step(254);
        check("thresh255 idle254 stop_req_o", stop_req, 1'b0);
        step();
        check("thresh255 idle255 stop_req_o", stop_req, 1'b1);
        busy = 1'b1;
        step();
        busy = 1'b0;
        check("abort busy stop_req_o", stop_req, 1'b0);
        step(10);
        thresh = 8'd5;
        step();
        check("thresh lowered stop_req_o", stop_req, 1'b1);
        thresh = 8'd4;
        stop_ack = 1'b1;
        step();
        stop_ack = 1'b0;

        // DFT override while gated.
        test_en = 1'b1;
        #1;
        check("test_en comb clk_en_o", clk_en, 1'b1);
        check("test_en gated_o", gated, 1'b1);
        step();
        check("test_en held clk_en_o", clk_en, 1'b1);
        test_en = 1'b0;
        #1;
        check("test_en off clk_en_o", clk_en, 1'b0);

        // Asynchronous reset in the middle of WAKE.
        wake = 1'b1;
        step();
        wake = 1'b0;
        step();
        check("mid-wake clk_ready_o", clk_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_all("async reset", 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        rst_n = 1'b1; busy = 1'b1;
        step();
        expect_all("post reset", 1'b1, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pulp_clock_gate_ctrl
